swap_stage: RTL

SWAP_STAGE -- requirements
Module: swap_stage

---
 rtl/swap_pkg.sv | 17 +
 rtl/lane_map.sv | 27 ++
 rtl/swap_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/swap_pkg.sv
// Shared types for the swap stage: lane-mapping modes and FIFO occupancy states.
package swap_pkg;

    typedef enum logic [1:0] {
        PASS    = 2'b00,
        SWAP    = 2'b01,
        BCAST_A = 2'b10,
        BCAST_B = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } occ_t;

endpackage

// File: rtl/lane_map.sv
// Combinational lane mapper: routes lanes a/b onto x/y according to mode.
module lane_map
    import swap_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  mode_t            mode,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    // Select the output lanes for the current mode
    always_comb begin
        x = a;
        y = b;
        case (mode)
            PASS:    begin x = a; y = b; end
            SWAP:    begin x = b; y = a; end
            BCAST_A: begin x = a; y = a; end
            BCAST_B: begin x = b; y = b; end
            default: begin x = a; y = b; end
        endcase
    end

endmodule

// File: rtl/swap_stage.sv
// Two-entry lane-mapping FIFO stage; lanes are mapped at capture time.
// Define SWAP_STAGE_CNT_EN to add the swap_cnt port counting delivered SWAP transactions.
module swap_stage
    import swap_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out
`ifdef SWAP_STAGE_CNT_EN
    ,
    output logic [CNT_W-1:0] swap_cnt
`endif
);

    if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_bad_param
        $error("swap_stage: WIDTH must be 1..64 and CNT_W at least 1");
    end

    occ_t             r_state;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [WIDTH-1:0] r_mem_a [2];
    logic [WIDTH-1:0] r_mem_b [2];
    logic [WIDTH-1:0] r_a_out;
    logic [WIDTH-1:0] r_b_out;
    logic [WIDTH-1:0] w_map_a;
    logic [WIDTH-1:0] w_map_b;
    logic             w_push;
    logic             w_pop;

    lane_map #(.WIDTH(WIDTH)) u_lane_map (
        .a    (a_in),
        .b    (b_in),
        .mode (mode_t'(mode)),
        .x    (w_map_a),
        .y    (w_map_b)
    );

    // Handshakes depend only on the registered occupancy, never on out_ready
    assign in_ready  = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign a_out     = r_a_out;
    assign b_out     = r_b_out;

    // Storage, pointers, occupancy and the registered head-of-queue outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_mem_a[0] <= '0;
            r_mem_a[1] <= '0;
            r_mem_b[0] <= '0;
            r_mem_b[1] <= '0;
            r_a_out    <= '0;
            r_b_out    <= '0;
        end else begin
            if (w_push) begin
                r_mem_a[r_wr_ptr] <= w_map_a;
                r_mem_b[r_wr_ptr] <= w_map_b;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Head only changes when a new entry becomes the oldest; EMPTY keeps the last value
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_state <= ONE;
                        r_a_out <= w_map_a;
                        r_b_out <= w_map_b;
                    end
                end
                ONE: begin
                    if (w_push && !w_pop) begin
                        r_state <= FULL;
                    end else if (!w_push && w_pop) begin
                        r_state <= EMPTY;
                    end else if (w_push && w_pop) begin
                        r_a_out <= w_map_a;
                        r_b_out <= w_map_b;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_state <= ONE;
                        r_a_out <= r_mem_a[~r_rd_ptr];
                        r_b_out <= r_mem_b[~r_rd_ptr];
                    end
                end
                default: begin
                    r_state <= EMPTY;
                end
            endcase
        end
    end

`ifdef SWAP_STAGE_CNT_EN
    logic             r_mem_swap [2];
    logic [CNT_W-1:0] r_swap_cnt;

    assign swap_cnt = r_swap_cnt;

    // Per-entry swap flag, counted only when its entry actually leaves the stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_swap[0] <= 1'b0;
            r_mem_swap[1] <= 1'b0;
            r_swap_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_mem_swap[r_wr_ptr] <= (mode_t'(mode) == SWAP);
            end
            if (w_pop && r_mem_swap[r_rd_ptr]) begin
                r_swap_cnt <= r_swap_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
